// File: rtl/button_events_if.sv
// Button event bus: debounced button level and enable in, event strobes and held level out.
interface button_events_if;
  logic btn_in;
  logic en;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;

  modport master (
    output btn_in, en,
    input  press_pulse, release_pulse, long_pulse, repeat_pulse, held
  );

  modport slave (
    input  btn_in, en,
    output press_pulse, release_pulse, long_pulse, repeat_pulse, held
  );
endinterface

// File: rtl/button_events.sv
// Turns a clean button level into press / release / long-press / auto-repeat strobes.
// A button already down at reset or enable is ignored until it has been seen released.
module button_events #(
  parameter int CNT_W         = 26,
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input logic           clk,
  input logic           rst,
  button_events_if.slave bus
);

  typedef enum logic [1:0] {LOCKOUT, IDLE, PRESSED, REPEAT} state_e;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q, release_q, long_q, repeat_q, held_q;

  // en=0 outranks everything, then release, then the hold thresholds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LOCKOUT;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      if (!bus.en) begin
        state_q <= LOCKOUT;
        cnt_q   <= '0;
        held_q  <= 1'b0;
      end else begin
        case (state_q)
          LOCKOUT: begin
            if (!bus.btn_in) state_q <= IDLE;
          end
          IDLE: begin
            if (bus.btn_in) begin
              state_q <= PRESSED;
              cnt_q   <= '0;
              press_q <= 1'b1;
              held_q  <= 1'b1;
            end
          end
          PRESSED: begin
            if (!bus.btn_in) begin
              state_q   <= IDLE;
              cnt_q     <= '0;
              release_q <= 1'b1;
              held_q    <= 1'b0;
            end else if (cnt_q == LONG_LAST) begin
              state_q <= REPEAT;
              cnt_q   <= '0;
              long_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          REPEAT: begin
            if (!bus.btn_in) begin
              state_q   <= IDLE;
              cnt_q     <= '0;
              release_q <= 1'b1;
              held_q    <= 1'b0;
            end else if (cnt_q == REPEAT_LAST) begin
              cnt_q    <= '0;
              repeat_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= LOCKOUT;
            cnt_q   <= '0;
            held_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.long_pulse    = long_q;
  assign bus.repeat_pulse  = repeat_q;
  assign bus.held          = held_q;

endmodule

// File: tb/tb_button_events.sv
// Scoreboarded random + directed bench for button_events (LONG=8, REPEAT=4, CNT_W=4).
module tb_button_events;
  localparam int L = 8;
  localparam int R = 4;

  logic clk, rst;
  button_events_if bus();

  button_events #(.CNT_W(4), .LONG_CYCLES(L), .REPEAT_CYCLES(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] exp_q[$];

  // Reference model: tracks whether the button has been seen released since
  // lockout, whether a press is active, and the edges elapsed since the press.
  bit m_armed  = 1'b0;
  bit m_active = 1'b0;
  int m_age    = 0;

  function automatic logic [4:0] outs();
    return {bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.repeat_pulse, bus.held};
  endfunction

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b (press,release,long,repeat,held) at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic btn, input logic en, output logic [4:0] e);
    logic p, r, lg, rp;
    p = 0; r = 0; lg = 0; rp = 0;
    if (!en) begin
      m_armed = 0; m_active = 0;
    end else if (!m_armed) begin
      if (!btn) m_armed = 1;
    end else if (!m_active) begin
      if (btn) begin m_active = 1; m_age = 0; p = 1; end
    end else if (!btn) begin
      m_active = 0; r = 1;
    end else begin
      m_age++;
      if (m_age == L) lg = 1;
      else if (m_age > L && (m_age - L) % R == 0) rp = 1;
    end
    e = {p, r, lg, rp, logic'(m_active)};
  endtask

  // One clock of stimulus, applied at the falling edge. With rst_pulse set, an
  // asynchronous reset is pulsed before the next rising edge and checked at once.
  task automatic cycle(input logic btn, input logic en, input logic rst_pulse);
    logic [4:0] e;
    @(negedge clk);
    bus.btn_in = btn;
    bus.en     = en;
    if (rst_pulse) begin m_armed = 0; m_active = 0; end
    model_step(btn, en, e);
    exp_q.push_back(e);
    if (rst_pulse) begin
      #2 rst = 1'b1;
      #1 check("async_reset", outs(), 5'b0);
      #1 rst = 1'b0;
    end
  endtask

  task automatic hold(input logic btn, input int n);
    for (int i = 0; i < n; i++) cycle(btn, 1'b1, 1'b0);
  endtask

  // Monitor: one expected vector per rising edge, compared just after it.
  initial begin
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("edge_outputs", outs(), e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.btn_in = 1'b1;
    bus.en     = 1'b1;
    #1 check("reset_state", outs(), 5'b0);
    #7 rst = 1'b0;

    // Held through reset release: silent until released and pressed again.
    hold(1'b1, 3);
    hold(1'b0, 2);
    hold(1'b1, 3);               // short press
    hold(1'b0, 3);
    hold(1'b1, 21);              // long press with three repeats
    hold(1'b0, 2);
    hold(1'b1, 8);               // release lands on the long edge
    hold(1'b0, 2);
    // en drops mid-press with the button still down.
    hold(1'b1, 5);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    hold(1'b1, 3);
    hold(1'b0, 1);
    hold(1'b1, 2);
    hold(1'b0, 2);
    // Async reset in the middle of auto-repeat.
    hold(1'b1, 14);
    cycle(1'b1, 1'b1, 1'b1);
    hold(1'b1, 2);
    hold(1'b0, 2);

    // Random segments of alternating level with occasional en drops and resets.
    begin
      logic lvl;
      lvl = 1'b1;
      for (int s = 0; s < 60; s++) begin
        int len;
        len = $urandom_range(1, 24);
        for (int i = 0; i < len; i++)
          cycle(lvl, ($urandom_range(0, 39) != 0), ($urandom_range(0, 99) == 0));
        lvl = ~lvl;
      end
    end

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
